// File: rtl/and_unit_arbiter_pkg.sv
// Shared types and constants for the two-requester AND-unit arbiter.
//   state_e   : arbiter FSM states
//   REQ_ID_W  : width of the requester tag
//   CNT_W     : latency counter width, sized for datapath depths up to 7
//   WIDTH_DEF / LAT_DEF : default operand width and datapath depth
package and_arb_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned LAT_DEF   = 1;
  localparam int unsigned REQ_ID_W  = 1;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/and_unit_arbiter_if.sv
// Request/response bundle between the tile I/O decode and the arbiter.
//   req0_*/req1_* : per-requester valid/ready channel with operand pair
//   resp_*        : tagged result channel, valid/ready
//   busy          : arbiter has a transaction in flight
// master = requester/consumer side, slave = arbiter side.
interface and_unit_arbiter_if #(
  parameter int unsigned WIDTH = and_arb_pkg::WIDTH_DEF
) ();
  import and_arb_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  logic [WIDTH-1:0]    req0_a;
  logic [WIDTH-1:0]    req0_b;
  logic                req1_valid;
  logic                req1_ready;
  logic [WIDTH-1:0]    req1_a;
  logic [WIDTH-1:0]    req1_b;
  logic                resp_valid;
  logic                resp_ready;
  logic [WIDTH-1:0]    resp_data;
  logic [REQ_ID_W-1:0] resp_id;
  logic                busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id, busy
  );

endinterface

// File: rtl/and_unit_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant.
//   valid_i       : request valids, bit N = requester N
//   ptr_i         : favoured requester when both are valid
//   grant_valid_o : some requester is granted
//   grant_id_o    : granted requester
module rr_arb2
  import and_arb_pkg::*;
(
  input  logic [1:0]          valid_i,
  input  logic [REQ_ID_W-1:0] ptr_i,
  output logic                grant_valid_o,
  output logic [REQ_ID_W-1:0] grant_id_o
);

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant_valid_o = |valid_i;
    grant_id_o    = (&valid_i) ? ptr_i : REQ_ID_W'(valid_i[1]);
  end

endmodule

// File: rtl/tt_um_clk_and.sv
// Clocked bitwise-AND datapath with LAT register stages.
//   clk, reset : clock and synchronous active-high reset
//   a_i, b_i   : operands
//   y_o        : a_i & b_i delayed by LAT cycles
module tt_um_clk_and
  import and_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LAT   = LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  // Stage 0 in the low slice, oldest stage in the high slice.
  logic [LAT*WIDTH-1:0] pipe_q;

  if (LAT == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (reset) pipe_q <= '0;
      else       pipe_q <= a_i & b_i;
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (reset) pipe_q <= '0;
      else       pipe_q <= {pipe_q[(LAT-1)*WIDTH-1:0], a_i & b_i};
    end
  end

  assign y_o = pipe_q[LAT*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/and_unit_arbiter.sv
// Shares one clocked AND datapath between two requesters, round-robin.
//   clk, reset : clock and synchronous active-high reset
//   bus        : request channels 0/1, tagged response channel, busy
// One transaction in flight: accept in IDLE, hold operands for LAT cycles
// in EXEC, present the result in RESP until the consumer takes it.
module and_unit_arbiter
  import and_arb_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LAT   = LAT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  and_unit_arbiter_if.slave    bus
);

  state_e              state_q, state_d;
  logic [REQ_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_ID_W-1:0] id_q, id_d;
  logic [WIDTH-1:0]    op_a_q, op_a_d;
  logic [WIDTH-1:0]    op_b_q, op_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                grant_valid;
  logic [REQ_ID_W-1:0] grant_id;
  logic [WIDTH-1:0]    dp_y;
  logic                resp_valid_c;

  rr_arb2 u_rr_arb2 (
    .valid_i       ({bus.req1_valid, bus.req0_valid}),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // Datapath sees the held operands; after LAT cycles its output is stable.
  tt_um_clk_and #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_dp (
    .clk   (clk),
    .reset (reset),
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .y_o   (dp_y)
  );

  // State and transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; in IDLE a grant is also the handshake.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d    = grant_id;
          op_a_d  = grant_id[0] ? bus.req1_a : bus.req0_a;
          op_b_d  = grant_id[0] ? bus.req1_b : bus.req0_b;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d  = IDLE;
          rr_ptr_d = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid_c   = (state_q == RESP);
  assign bus.req0_ready = (state_q == IDLE) && grant_valid && (grant_id == '0);
  assign bus.req1_ready = (state_q == IDLE) && grant_valid && (grant_id != '0);
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_data  = resp_valid_c ? dp_y : '0;
  assign bus.resp_id    = resp_valid_c ? id_q : '0;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Bench for and_unit_arbiter: a LAT=1 instance (index 0) and a LAT=3
// instance (index 1). A transaction-level model predicts every output each
// cycle; directed literals pin the model.
module tb_and_unit_arbiter;
  import and_arb_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   armed = 1'b0;

  always #5 clk = ~clk;

  and_unit_arbiter_if #(.WIDTH(W)) bus_a ();
  and_unit_arbiter_if #(.WIDTH(W)) bus_b ();

  and_unit_arbiter #(.WIDTH(W), .LAT(LAT_A)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  and_unit_arbiter #(.WIDTH(W), .LAT(LAT_B)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // Stimulus per instance
  logic         v0_s[2], v1_s[2], rr_s[2];
  logic [W-1:0] a0_s[2], b0_s[2], a1_s[2], b1_s[2];
  // Observed outputs per instance
  logic         r0_o[2], r1_o[2], rv_o[2], id_o[2], bsy_o[2];
  logic [W-1:0] rd_o[2];

  assign bus_a.req0_valid = v0_s[0];  assign bus_b.req0_valid = v0_s[1];
  assign bus_a.req0_a     = a0_s[0];  assign bus_b.req0_a     = a0_s[1];
  assign bus_a.req0_b     = b0_s[0];  assign bus_b.req0_b     = b0_s[1];
  assign bus_a.req1_valid = v1_s[0];  assign bus_b.req1_valid = v1_s[1];
  assign bus_a.req1_a     = a1_s[0];  assign bus_b.req1_a     = a1_s[1];
  assign bus_a.req1_b     = b1_s[0];  assign bus_b.req1_b     = b1_s[1];
  assign bus_a.resp_ready = rr_s[0];  assign bus_b.resp_ready = rr_s[1];

  assign r0_o[0]  = bus_a.req0_ready; assign r0_o[1]  = bus_b.req0_ready;
  assign r1_o[0]  = bus_a.req1_ready; assign r1_o[1]  = bus_b.req1_ready;
  assign rv_o[0]  = bus_a.resp_valid; assign rv_o[1]  = bus_b.resp_valid;
  assign rd_o[0]  = bus_a.resp_data;  assign rd_o[1]  = bus_b.resp_data;
  assign id_o[0]  = bus_a.resp_id[0]; assign id_o[1]  = bus_b.resp_id[0];
  assign bsy_o[0] = bus_a.busy;       assign bsy_o[1] = bus_b.busy;

  // Model: at most one outstanding op, result due at handshake cycle + LAT + 1.
  bit           m_busy[2];
  bit           m_id[2];
  bit           m_ptr[2];
  logic [W-1:0] m_res[2];
  int           m_due[2];
  int           lat_of[2] = '{int'(LAT_A), int'(LAT_B)};

  // Protocol monitor history and instance-0 transaction log
  logic           pv0[2], pv1[2], pr0[2], pr1[2];
  logic [2*W-1:0] pab0[2], pab1[2];
  logic [W-1:0]   rsp_dat_q[$];
  logic           rsp_id_q[$];
  int             hs_q[$];

  function automatic bit exp_ready(input bit busy, input bit mine, input bit other,
                                   input bit ptr, input bit me);
    return !busy && mine && (!other || ptr == me);
  endfunction

  function automatic bit grant_of(input bit v0, input bit v1, input bit ptr);
    return (v0 && v1) ? ptr : v1;
  endfunction

  task automatic check(input int d, input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", d, name, got, exp, cyc);
    end
  endtask

  // Model update, protocol monitor and response log on the active edge.
  always @(posedge clk) begin
    armed <= armed | reset;
    cyc   <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (armed && !reset) begin
        if (pv0[d] && !pr0[d] && v0_s[d])
          assert ({a0_s[d], b0_s[d]} == pab0[d]) else $error("req0 operands changed while waiting");
        if (pv1[d] && !pr1[d] && v1_s[d])
          assert ({a1_s[d], b1_s[d]} == pab1[d]) else $error("req1 operands changed while waiting");
      end
      pv0[d]  <= v0_s[d];
      pv1[d]  <= v1_s[d];
      pr0[d]  <= r0_o[d];
      pr1[d]  <= r1_o[d];
      pab0[d] <= {a0_s[d], b0_s[d]};
      pab1[d] <= {a1_s[d], b1_s[d]};

      if (reset) begin
        m_busy[d] <= 1'b0;
        m_ptr[d]  <= 1'b0;
      end else if (m_busy[d]) begin
        if (cyc >= m_due[d] && rr_s[d]) begin
          m_busy[d] <= 1'b0;
          m_ptr[d]  <= !m_id[d];
        end
      end else if (v0_s[d] || v1_s[d]) begin
        m_busy[d] <= 1'b1;
        m_id[d]   <= grant_of(v0_s[d], v1_s[d], m_ptr[d]);
        m_res[d]  <= grant_of(v0_s[d], v1_s[d], m_ptr[d]) ? (a1_s[d] & b1_s[d])
                                                          : (a0_s[d] & b0_s[d]);
        m_due[d]  <= cyc + lat_of[d] + 1;
      end
    end
    if (armed && !reset) begin
      if (rv_o[0] && rr_s[0]) begin
        rsp_dat_q.push_back(rd_o[0]);
        rsp_id_q.push_back(id_o[0]);
      end
      if ((v0_s[0] && r0_o[0]) || (v1_s[0] && r1_o[0])) hs_q.push_back(cyc);
    end
  end

  task automatic cmp_dut(input int d);
    logic erv;
    erv = m_busy[d] && (cyc >= m_due[d]);
    check(d, "busy",       32'(bsy_o[d]), 32'(m_busy[d]));
    check(d, "resp_valid", 32'(rv_o[d]),  32'(erv));
    check(d, "req0_ready", 32'(r0_o[d]),  32'(exp_ready(m_busy[d], v0_s[d], v1_s[d], m_ptr[d], 1'b0)));
    check(d, "req1_ready", 32'(r1_o[d]),  32'(exp_ready(m_busy[d], v1_s[d], v0_s[d], m_ptr[d], 1'b1)));
    check(d, "one_ready",  32'(r0_o[d] & r1_o[d]), 32'(0));
    if (erv) begin
      check(d, "resp_data", 32'(rd_o[d]), 32'(m_res[d]));
      check(d, "resp_id",   32'(id_o[d]), 32'(m_id[d]));
    end
  endtask

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      cmp_dut(0);
      cmp_dut(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input int d, input string tag);
    @(negedge clk);
    check(d, {tag, ".busy"},       32'(bsy_o[d]), 32'(0));
    check(d, {tag, ".resp_valid"}, 32'(rv_o[d]),  32'(0));
    check(d, {tag, ".resp_data"},  32'(rd_o[d]),  32'(0));
    check(d, {tag, ".resp_id"},    32'(id_o[d]),  32'(0));
    check(d, {tag, ".req0_ready"}, 32'(r0_o[d]),  32'(0));
    check(d, {tag, ".req1_ready"}, 32'(r1_o[d]),  32'(0));
  endtask

  // Hold requests until each handshakes, for n cycles.
  task automatic serve(input int d, input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g0 = r0_o[d] && v0_s[d];
      g1 = r1_o[d] && v1_s[d];
      tick();
      if (g0) v0_s[d] = 1'b0;
      if (g1) v1_s[d] = 1'b0;
    end
  endtask

  initial begin
    int n0;
    for (int d = 0; d < 2; d++) begin
      v0_s[d] = 1'b0; v1_s[d] = 1'b0; rr_s[d] = 1'b1;
      a0_s[d] = '0; b0_s[d] = '0; a1_s[d] = '0; b1_s[d] = '0;
    end
    repeat (2) tick();
    reset = 1'b0;
    chk_idle_zero(0, "after_reset");

    // Single request, LAT=1: 0xF0 & 0x3C
    tick();
    v0_s[0] = 1'b1; a0_s[0] = 8'hF0; b0_s[0] = 8'h3C;
    @(negedge clk); check(0, "single.ready_c0", 32'(r0_o[0]), 32'(1));
    tick(); v0_s[0] = 1'b0;
    @(negedge clk); check(0, "single.busy_c1", 32'(bsy_o[0]), 32'(1));
    check(0, "single.valid_c1", 32'(rv_o[0]), 32'(0));
    tick();
    @(negedge clk); check(0, "single.valid_c2", 32'(rv_o[0]), 32'(1));
    check(0, "single.data_c2", 32'(rd_o[0]), 32'(8'h30));
    check(0, "single.id_c2", 32'(id_o[0]), 32'(0));
    tick();
    @(negedge clk); check(0, "single.valid_c3", 32'(rv_o[0]), 32'(0));
    check(0, "single.busy_c3", 32'(bsy_o[0]), 32'(0));

    // Reset held two cycles during EXEC discards the op
    n0 = rsp_dat_q.size();
    v0_s[0] = 1'b1; a0_s[0] = 8'h77; b0_s[0] = 8'hFF;
    tick(); v0_s[0] = 1'b0; reset = 1'b1;
    tick();
    tick(); reset = 1'b0;
    chk_idle_zero(0, "mid_reset");
    tick();
    v0_s[0] = 1'b1; a0_s[0] = 8'h0F; b0_s[0] = 8'hFF;
    serve(0, 5);
    check(0, "mid_reset.resp_count", 32'(rsp_dat_q.size()), 32'(n0 + 1));
    check(0, "mid_reset.data", 32'(rsp_dat_q[$]), 32'(8'h0F));
    check(0, "mid_reset.id", 32'(rsp_id_q[$]), 32'(0));

    // Contention after reset, then re-presented
    reset = 1'b1; tick(); reset = 1'b0;
    n0 = rsp_dat_q.size();
    for (int k = 0; k < 2; k++) begin
      v0_s[0] = 1'b1; a0_s[0] = 8'hFF; b0_s[0] = 8'h0F;
      v1_s[0] = 1'b1; a1_s[0] = 8'hAA; b1_s[0] = 8'hFF;
      serve(0, 8);
    end
    check(0, "contend.count", 32'(rsp_dat_q.size()), 32'(n0 + 4));
    check(0, "contend.id0", 32'(rsp_id_q[n0]),   32'(0));
    check(0, "contend.d0",  32'(rsp_dat_q[n0]),  32'(8'h0F));
    check(0, "contend.id1", 32'(rsp_id_q[n0+1]), 32'(1));
    check(0, "contend.d1",  32'(rsp_dat_q[n0+1]), 32'(8'hAA));
    check(0, "contend.id2", 32'(rsp_id_q[n0+2]), 32'(0));
    check(0, "contend.id3", 32'(rsp_id_q[n0+3]), 32'(1));

    // Backpressure: 5 cycles in RESP with resp_ready low, req1 waiting
    rr_s[0] = 1'b0;
    v0_s[0] = 1'b1; a0_s[0] = 8'h12; b0_s[0] = 8'h34;
    @(negedge clk); check(0, "bp.ready0", 32'(r0_o[0]), 32'(1));
    tick(); v0_s[0] = 1'b0;
    v1_s[0] = 1'b1; a1_s[0] = 8'hFF; b1_s[0] = 8'hF0;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      check(0, "bp.valid", 32'(rv_o[0]), 32'(1));
      check(0, "bp.data",  32'(rd_o[0]), 32'(8'h10));
      check(0, "bp.id",    32'(id_o[0]), 32'(0));
      check(0, "bp.rdy1",  32'(r1_o[0]), 32'(0));
      check(0, "bp.busy",  32'(bsy_o[0]), 32'(1));
    end
    tick(); rr_s[0] = 1'b1;
    tick();
    @(negedge clk); check(0, "bp.idle_busy", 32'(bsy_o[0]), 32'(0));
    check(0, "bp.idle_rdy1", 32'(r1_o[0]), 32'(1));
    tick(); v1_s[0] = 1'b0;
    repeat (3) tick();
    check(0, "bp.last_id",   32'(rsp_id_q[$]),  32'(1));
    check(0, "bp.last_data", 32'(rsp_dat_q[$]), 32'(8'hF0));

    // Lone requester 1, continuously valid
    n0 = hs_q.size();
    v1_s[0] = 1'b1; a1_s[0] = 8'h55; b1_s[0] = 8'hFF;
    tick(); a1_s[0] = 8'h3C; b1_s[0] = 8'h0F;
    tick();
    tick();
    @(negedge clk); check(0, "lone.rdy1_c3", 32'(r1_o[0]), 32'(1));
    tick(); v1_s[0] = 1'b0;
    repeat (3) tick();
    check(0, "lone.hs_count", 32'(hs_q.size()), 32'(n0 + 2));
    check(0, "lone.interval", 32'(hs_q[n0+1] - hs_q[n0]), 32'(3));
    check(0, "lone.d0", 32'(rsp_dat_q[rsp_dat_q.size()-2]), 32'(8'h55));
    check(0, "lone.d1", 32'(rsp_dat_q[$]), 32'(8'h0C));
    check(0, "lone.id", 32'(rsp_id_q[$]), 32'(1));

    // LAT=3 instance: 0xC3 & 0x81
    v0_s[1] = 1'b1; a0_s[1] = 8'hC3; b0_s[1] = 8'h81;
    @(negedge clk); check(1, "lat3.ready_c0", 32'(r0_o[1]), 32'(1));
    tick(); v0_s[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); check(1, "lat3.valid_early", 32'(rv_o[1]), 32'(0));
      check(1, "lat3.busy", 32'(bsy_o[1]), 32'(1));
      tick();
    end
    @(negedge clk); check(1, "lat3.valid_c4", 32'(rv_o[1]), 32'(1));
    check(1, "lat3.data_c4", 32'(rd_o[1]), 32'(8'h81));
    check(1, "lat3.id_c4", 32'(id_o[1]), 32'(0));
    tick();
    @(negedge clk); check(1, "lat3.busy_c5", 32'(bsy_o[1]), 32'(0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
